axi_burst_ram_slave: RTL and testbench

- AXI-subset responder (slave) backed by an internal word RAM; the memory-side counterpart of the d-cache/i-cache AXI master ports (ar/r/aw/w/b subset, no IDs, INCR bursts only).
- Serves cache line fills and write-backs in block-level benches and FPGA bring-up.
- Independent read and write engines run concurrently.

---
 rtl/axi_burst_ram_slave.sv | 158 +++++++++++++++
 tb/tb_axi_burst_ram_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_ram_slave.sv
// AXI-subset burst RAM responder with independent read and write engines.
// Define AXI_SLAVE_STALL_EN to add LFSR-driven random handshake stalls.
module axi_burst_ram_slave #(
   parameter int DEPTH_LOG2 = 12,
   parameter int MAX_LEN    = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic [3:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic        bvalid,
   input  logic        bready,
   output logic        prot_err
);

   localparam int         DEPTH = 1 << DEPTH_LOG2;
   localparam logic [4:0] MAXL  = 5'(MAX_LEN);

   typedef enum logic {R_IDLE, R_BURST} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

   logic [31:0] mem [DEPTH];

   r_state_e              r_state_q, r_state_d;
   logic [DEPTH_LOG2-1:0] r_idx_q, r_idx_d;
   logic [3:0]            r_cnt_q, r_cnt_d;
   w_state_e              w_state_q, w_state_d;
   logic [DEPTH_LOG2-1:0] w_idx_q, w_idx_d;
   logic [3:0]            w_cnt_q, w_cnt_d;
   logic                  prot_err_q, prot_err_d;
   logic                  stall;

   logic [4:0] ar_diff, aw_diff;
   logic [3:0] ar_len, aw_len;
   logic       ar_over, aw_over;
   logic       w_fire;
   logic       unused_bits;

`ifdef AXI_SLAVE_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0],
                lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk) begin
      if (!rst) lfsr_q <= 16'hACE1;
      else      lfsr_q <= lfsr_d;
   end

   assign stall = lfsr_q[0];
`else
   assign stall = 1'b0;
`endif

   // Clamp via subtraction so the check stays generic in MAX_LEN.
   assign ar_diff = MAXL - {1'b0, arlen};
   assign aw_diff = MAXL - {1'b0, awlen};
   assign ar_over = ar_diff[4];
   assign aw_over = aw_diff[4];
   assign ar_len  = ar_over ? MAXL[3:0] : arlen;
   assign aw_len  = aw_over ? MAXL[3:0] : awlen;

   assign arready  = (r_state_q == R_IDLE) && !stall;
   assign rvalid   = (r_state_q == R_BURST) && !stall;
   assign rlast    = (r_state_q == R_BURST) && (r_cnt_q == 4'd0);
   assign rdata    = mem[r_idx_q];
   assign awready  = (w_state_q == W_IDLE) && !stall;
   assign wready   = (w_state_q == W_DATA) && !stall;
   assign bvalid   = (w_state_q == W_RESP);
   assign prot_err = prot_err_q;
   assign w_fire   = wvalid && wready;

   assign unused_bits = ^{araddr[31:DEPTH_LOG2+2], araddr[1:0],
                          awaddr[31:DEPTH_LOG2+2], awaddr[1:0]};

   always_comb begin
      r_state_d  = r_state_q;
      r_idx_d    = r_idx_q;
      r_cnt_d    = r_cnt_q;
      w_state_d  = w_state_q;
      w_idx_d    = w_idx_q;
      w_cnt_d    = w_cnt_q;
      prot_err_d = prot_err_q;
      if (arvalid && arready) begin
         r_state_d = R_BURST;
         r_idx_d   = araddr[DEPTH_LOG2+1:2];
         r_cnt_d   = ar_len;
         if (ar_over || arsize != 3'b010) prot_err_d = 1'b1;
      end
      if (rvalid && rready) begin
         r_idx_d = r_idx_q + 1'b1;
         r_cnt_d = r_cnt_q - 1'b1;
         if (rlast) r_state_d = R_IDLE;
      end
      if (awvalid && awready) begin
         w_state_d = W_DATA;
         w_idx_d   = awaddr[DEPTH_LOG2+1:2];
         w_cnt_d   = aw_len;
         if (aw_over || awsize != 3'b010) prot_err_d = 1'b1;
      end
      // Beat count ends the burst; wlast is only cross-checked.
      if (w_fire) begin
         w_idx_d = w_idx_q + 1'b1;
         w_cnt_d = w_cnt_q - 1'b1;
         if (wlast != (w_cnt_q == 4'd0)) prot_err_d = 1'b1;
         if (w_cnt_q == 4'd0) w_state_d = W_RESP;
      end
      if (bvalid && bready) w_state_d = W_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state_q  <= R_IDLE;
         r_idx_q    <= '0;
         r_cnt_q    <= '0;
         w_state_q  <= W_IDLE;
         w_idx_q    <= '0;
         w_cnt_q    <= '0;
         prot_err_q <= 1'b0;
      end else begin
         r_state_q  <= r_state_d;
         r_idx_q    <= r_idx_d;
         r_cnt_q    <= r_cnt_d;
         w_state_q  <= w_state_d;
         w_idx_q    <= w_idx_d;
         w_cnt_q    <= w_cnt_d;
         prot_err_q <= prot_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && w_fire) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[w_idx_q][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Scoreboard bench for axi_burst_ram_slave: directed bursts, strobes,
// wrap, protocol errors, reset and concurrent read/write traffic.
module tb_axi_burst_ram_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] araddr = '0;
   logic [3:0]  arlen = '0;
   logic [2:0]  arsize = 3'b010;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic        rlast;
   logic        rvalid;
   logic        rready = 1'b1;
   logic [31:0] awaddr = '0;
   logic [3:0]  awlen = '0;
   logic [2:0]  awsize = 3'b010;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wlast = 1'b0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic        bvalid;
   logic        bready = 1'b1;
   logic        prot_err;

   int n_assert = 0;
   int n_fail   = 0;
   logic [32:0] rq[$];
   int bq_n = 0;

   axi_burst_ram_slave #(.DEPTH_LOG2(12), .MAX_LEN(15)) dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready), .prot_err(prot_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Read-data and write-response monitor.
   always @(negedge clk) begin
      if (rst && rvalid) begin
         if (rq.size() == 0) begin
            chk("r_unexpected_beat", 32'd1, 32'd0);
         end else begin
            chk("rdata", rdata, rq[0][31:0]);
            chk("rlast", {31'b0, rlast}, {31'b0, rq[0][32]});
            if (rready) void'(rq.pop_front());
         end
      end
      if (rst && bvalid && bready) begin
         if (bq_n == 0) chk("b_unexpected", 32'd1, 32'd0);
         else bq_n--;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_r(input logic [31:0] d, input logic l);
      rq.push_back({l, d});
   endtask

   task automatic ar(input logic [31:0] a, input logic [3:0] len,
                     input logic [2:0] sz);
      bit ok = 0;
      araddr = a; arlen = len; arsize = sz; arvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (arready) begin ok = 1; break; end
      end
      chk("ar_handshake", {31'b0, ok}, 32'd1);
      tick();
      arvalid = 1'b0;
   endtask

   task automatic aw(input logic [31:0] a, input logic [3:0] len,
                     input logic [2:0] sz);
      bit ok = 0;
      bq_n++;
      awaddr = a; awlen = len; awsize = sz; awvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (awready) begin ok = 1; break; end
      end
      chk("aw_handshake", {31'b0, ok}, 32'd1);
      tick();
      awvalid = 1'b0;
   endtask

   task automatic wbeat(input logic [31:0] d, input logic [3:0] s,
                        input logic l);
      bit ok = 0;
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (wready) begin ok = 1; break; end
      end
      chk("w_handshake", {31'b0, ok}, 32'd1);
      tick();
      wvalid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         if (rq.size() == 0 && bq_n == 0) begin ok = 1; break; end
      end
      chk(name, {31'b0, ok}, 32'd1);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      @(negedge clk);
`ifndef AXI_SLAVE_STALL_EN
      chk("rst_arready", {31'b0, arready}, 32'd1);
      chk("rst_awready", {31'b0, awready}, 32'd1);
`endif
      chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("rst_rlast", {31'b0, rlast}, 32'd0);
      chk("rst_wready", {31'b0, wready}, 32'd0);
      chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
      chk("rst_prot_err", {31'b0, prot_err}, 32'd0);
      tick();

      // Single beat write then read.
      aw(32'h100, 4'd0, 3'b010);
      wbeat(32'hDEADBEEF, 4'hF, 1'b1);
      @(negedge clk);
      chk("single_bvalid", {31'b0, bvalid}, 32'd1);
      tick();
      wait_idle("single_write_done");
      exp_r(32'hDEADBEEF, 1'b1);
      ar(32'h100, 4'd0, 3'b010);
      wait_idle("single_read_done");
      chk("single_prot_err", {31'b0, prot_err}, 32'd0);

      // Cache line fill.
      aw(32'h2000, 4'd15, 3'b010);
      for (int i = 0; i < 16; i++) wbeat(32'h1000 + i, 4'hF, i == 15);
      wait_idle("fill_write_done");
      for (int i = 0; i < 16; i++) exp_r(32'h1000 + i, i == 15);
      ar(32'h2000, 4'd15, 3'b010);
      wait_idle("fill_read_done");
      @(negedge clk);
`ifndef AXI_SLAVE_STALL_EN
      chk("fill_arready_after", {31'b0, arready}, 32'd1);
`endif
      tick();

      // Byte strobes and read backpressure.
      aw(32'h40, 4'd1, 3'b010);
      wbeat(32'h11223344, 4'hF, 1'b0);
      wbeat(32'h55667788, 4'hF, 1'b1);
      wait_idle("strb_write1_done");
      aw(32'h40, 4'd0, 3'b010);
      wbeat(32'hAABBCCDD, 4'b0101, 1'b1);
      wait_idle("strb_write2_done");
      rready = 1'b0;
      exp_r(32'h11BB33DD, 1'b1);
      ar(32'h40, 4'd0, 3'b010);
      tick(); tick();
      rready = 1'b1;
      wait_idle("strb_read_done");

      // Wrap at the top of the RAM.
      aw(32'h3FF8, 4'd3, 3'b010);
      for (int i = 0; i < 4; i++) wbeat(i + 1, 4'hF, i == 3);
      wait_idle("wrap_write_done");
      for (int i = 0; i < 4; i++) exp_r(i + 1, i == 3);
      ar(32'h3FF8, 4'd3, 3'b010);
      wait_idle("wrap_read_done");
      exp_r(32'd3, 1'b1);
      ar(32'h0000, 4'd0, 3'b010);
      wait_idle("wrap_read_low_done");
      chk("wrap_prot_err", {31'b0, prot_err}, 32'd0);

      // Early wlast: flagged, but burst still runs four beats.
      aw(32'h300, 4'd3, 3'b010);
      wbeat(32'hA0, 4'hF, 1'b0);
      wbeat(32'hA1, 4'hF, 1'b1);
      @(negedge clk);
      chk("err_prot_err", {31'b0, prot_err}, 32'd1);
      tick();
      wbeat(32'hA2, 4'hF, 1'b0);
      @(negedge clk);
      chk("err_no_early_b", {31'b0, bvalid}, 32'd0);
      tick();
      wbeat(32'hA3, 4'hF, 1'b1);
      @(negedge clk);
      chk("err_bvalid", {31'b0, bvalid}, 32'd1);
      tick();
      wait_idle("err_write_done");

      // Reset in the middle of a read burst.
      for (int i = 0; i < 16; i++) exp_r(32'h1000 + i, i == 15);
      ar(32'h2000, 4'd15, 3'b010);
      tick(); tick(); tick();
      rready = 1'b0;
      rq.delete();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      rready = 1'b1;
      @(negedge clk);
      chk("rst_mid_rvalid", {31'b0, rvalid}, 32'd0);
`ifndef AXI_SLAVE_STALL_EN
      chk("rst_mid_arready", {31'b0, arready}, 32'd1);
`endif
      chk("rst_mid_prot_err", {31'b0, prot_err}, 32'd0);
      tick();
      exp_r(32'h1000, 1'b1);
      ar(32'h2000, 4'd0, 3'b010);
      wait_idle("rst_retained_done");

      // Unsupported arsize still served as 32-bit beats.
      exp_r(32'hDEADBEEF, 1'b1);
      ar(32'h100, 4'd0, 3'b000);
      wait_idle("size_read_done");
      chk("size_prot_err", {31'b0, prot_err}, 32'd1);

      // Concurrent AR and AW handshakes.
      exp_r(32'h11BB33DD, 1'b0);
      exp_r(32'h55667788, 1'b1);
      fork
         ar(32'h40, 4'd1, 3'b010);
         begin
            aw(32'h800, 4'd1, 3'b010);
            wbeat(32'hCAFE0001, 4'hF, 1'b0);
            wbeat(32'hCAFE0002, 4'hF, 1'b1);
         end
      join
      wait_idle("conc_done");
      exp_r(32'hCAFE0001, 1'b0);
      exp_r(32'hCAFE0002, 1'b1);
      ar(32'h800, 4'd1, 3'b010);
      wait_idle("conc_readback_done");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
